// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite slave backed by word-organised on-chip memory, byte/half/word writes, two-cycle ERROR.
// Define AHB_SLAVE_WAIT_EN to insert WAIT_STATES wait cycles before every valid data phase.
module ahb_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [AW-1:0] idx_q;
  logic [1:0] off_q;
  logic [2:0] size_q;
  logic wr_q, open_slot, accept, bad;
  logic [3:0] be;
  logic unused;
  assign unused = ^{HTRANS[0], HBURST, HPROT, 4'(WAIT_STATES)};
  assign open_slot = state == IDLE || state == DATA || state == ERR2;
  assign accept = open_slot && HSEL && HREADY && HTRANS[1];
  assign bad = HADDR >= ADDR_WIDTH'(DEPTH * 4) || HSIZE > 3'd2 ||
               (HSIZE == 3'd1 && HADDR[0]) || (HSIZE == 3'd2 && HADDR[1:0] != 2'd0);
  assign be = size_q == 3'd0 ? 4'b0001 << off_q : size_q == 3'd1 ? (off_q[1] ? 4'b1100 : 4'b0011) : 4'hf;
  assign HREADYOUT = !(state == WAIT || state == ERR1);
  assign HRESP = (state == ERR1 || state == ERR2) ? 2'b01 : 2'b00;
  // Reads come straight from the array so a write committed on the previous edge is visible.
  assign HRDATA = (state == DATA && !wr_q) ? mem[idx_q] : rdata_q;
`ifdef AHB_SLAVE_WAIT_EN
  logic [3:0] cnt_q;
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) cnt_q <= '0;
    else if (accept) cnt_q <= 4'(WAIT_STATES - 1);
    else if (state == WAIT && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
  end
`endif
  always_comb begin
    state_nx = state;
    if (open_slot) begin
      if (!accept) state_nx = IDLE;
      else if (bad) state_nx = ERR1;
`ifdef AHB_SLAVE_WAIT_EN
      else if (WAIT_STATES != 0) state_nx = WAIT;
`endif
      else state_nx = DATA;
    end
    else if (state == ERR1) state_nx = ERR2;
`ifdef AHB_SLAVE_WAIT_EN
    else if (cnt_q == 4'd0) state_nx = DATA;
`endif
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= IDLE;
      rdata_q <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == DATA && !wr_q) rdata_q <= mem[idx_q];
      if (accept) begin
        idx_q  <= HADDR[AW+1:2];
        off_q  <= HADDR[1:0];
        size_q <= HSIZE;
        wr_q   <= HWRITE;
      end
    end
  end
  always_ff @(posedge HCLK) begin
    if (state == DATA && wr_q)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
  end
endmodule
